// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add sequencer.
// Contents: sequencer state enum, special-result code enum, field widths,
// normalisation timeout, alignment-shift saturation value, and a helper
// that computes the saturated alignment shift from two exponents.
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int NORM_MAX  = 26;
  // Shifting by more than the full significand (hidden bit + MAN_W) only
  // feeds sticky bits, so the shift amount saturates there.
  localparam int SHAMT_SAT = MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_ALIGN   = 3'd2,
    S_ADD     = 3'd3,
    S_NORM    = 3'd4,
    S_ROUND   = 3'd5,
    S_SPECIAL = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_QNAN = 2'b01,
    SP_INF  = 2'b10,
    SP_RSVD = 2'b11
  } special_t;

  function automatic logic [4:0] sat_shamt(input logic [EXP_W-1:0] ea,
                                           input logic [EXP_W-1:0] eb);
    logic [EXP_W-1:0] d;
    d = (ea >= eb) ? (ea - eb) : (eb - ea);
    if (d > EXP_W'(SHAMT_SAT)) return 5'(SHAMT_SAT);
    else                       return d[4:0];
  endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational classification of one single-precision operand.
// Ports:
//   exponent  in  8  biased exponent field
//   man_nz    in  1  mantissa field is nonzero
//   is_zden   out 1  zero or denormal (exponent all zeros)
//   is_inf    out 1  infinity (exponent all ones, mantissa zero)
//   is_nan    out 1  NaN (exponent all ones, mantissa nonzero)
module fp_class
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0] exponent,
  input  logic             man_nz,
  output logic             is_zden,
  output logic             is_inf,
  output logic             is_nan
);

  logic exp_max;

  assign exp_max = (exponent == EXP_ALL1);
  assign is_zden = (exponent == '0);
  assign is_inf  = exp_max & ~man_nz;
  assign is_nan  = exp_max &  man_nz;

endmodule

// File: rtl/fp_add_seq.sv
// Control sequencer for a multi-cycle floating-point adder. Accepts an
// operand pair (sign, exponent, mantissa-nonzero flags), derives the
// alignment controls, steps the datapath through align/add/normalise/round
// with one stage enable at a time, and short-circuits NaN/Inf operands.
//
// Optional feature: define FPU_SUB_EN to add the op_sub port (1 = A-B),
// which then enters the effective-subtract decision.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only when idle)
//   sign_*, exp_*, man_*_nz  operand fields
//   op_sub                subtract request (FPU_SUB_EN only)
//   swap                  B has the larger exponent
//   n_concat              {A is zero/denorm, B is zero/denorm}
//   shamt                 alignment shift, saturated at 24
//   eff_sub               effective operation is a subtraction
//   ld_en..round_en       datapath stage enables, at most one high
//   norm_done             datapath reports normalisation complete
//   special               00 none, 01 qNaN, 10 Inf
//   out_valid / out_ready result handshake, outputs held while waiting
//   norm_err              sticky: normalisation timed out
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | ready for an operand pair; accept pulses ld_en
// S_UNPACK  | classify latched operands, register alignment controls
// S_ALIGN   | one cycle of align_en
// S_ADD     | one cycle of add_en; arm normalisation timer
// S_NORM    | norm_en until norm_done or timer terminal count
// S_ROUND   | one cycle of round_en
// S_SPECIAL | register NaN/Inf code, no datapath enables
// S_DONE    | out_valid held until out_ready
module fp_add_seq
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             man_a_nz,
  input  logic             man_b_nz,
`ifdef FPU_SUB_EN
  input  logic             op_sub,
`endif
  output logic             swap,
  output logic [1:0]       n_concat,
  output logic [4:0]       shamt,
  output logic             eff_sub,
  output logic             ld_en,
  output logic             align_en,
  output logic             add_en,
  output logic             norm_en,
  output logic             round_en,
  input  logic             norm_done,
  output logic [1:0]       special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             norm_err
);

  state_t state, state_nxt;

  // Operand fields captured at accept so the source may move on.
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             a_mnz, b_mnz;
  logic             sub_req;
  logic [4:0]       norm_cnt;

  logic a_zden, a_inf, a_nan;
  logic b_zden, b_inf, b_nan;
  logic any_special;
  logic is_qnan;
  logic norm_tc;

  fp_class u_class_a (
    .exponent (a_exp),
    .man_nz   (a_mnz),
    .is_zden  (a_zden),
    .is_inf   (a_inf),
    .is_nan   (a_nan)
  );

  fp_class u_class_b (
    .exponent (b_exp),
    .man_nz   (b_mnz),
    .is_zden  (b_zden),
    .is_inf   (b_inf),
    .is_nan   (b_nan)
  );

  assign any_special = a_inf | a_nan | b_inf | b_nan;
  // Inf - Inf is invalid; eff_sub is already registered by the time
  // SPECIAL evaluates this.
  assign is_qnan     = a_nan | b_nan | (a_inf & b_inf & eff_sub);
  assign norm_tc     = (norm_cnt == 5'd0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_en     = 1'b0;
    align_en  = 1'b0;
    add_en    = 1'b0;
    norm_en   = 1'b0;
    round_en  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_en     = 1'b1;
          state_nxt = S_UNPACK;
        end
      end
      S_UNPACK:  state_nxt = any_special ? S_SPECIAL : S_ALIGN;
      S_ALIGN: begin
        align_en  = 1'b1;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        add_en    = 1'b1;
        state_nxt = S_NORM;
      end
      S_NORM: begin
        norm_en = 1'b1;
        if (norm_done || norm_tc) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        round_en  = 1'b1;
        state_nxt = S_DONE;
      end
      S_SPECIAL: state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      a_exp    <= '0;
      b_exp    <= '0;
      a_mnz    <= 1'b0;
      b_mnz    <= 1'b0;
      sub_req  <= 1'b0;
      swap     <= 1'b0;
      n_concat <= 2'b00;
      shamt    <= 5'd0;
      eff_sub  <= 1'b0;
      special  <= SP_NONE;
      norm_cnt <= 5'd0;
      norm_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_en) begin
        a_sign   <= sign_a;
        b_sign   <= sign_b;
        a_exp    <= exp_a;
        b_exp    <= exp_b;
        a_mnz    <= man_a_nz;
        b_mnz    <= man_b_nz;
`ifdef FPU_SUB_EN
        sub_req  <= op_sub;
`else
        sub_req  <= 1'b0;
`endif
        swap     <= 1'b0;
        n_concat <= 2'b00;
        shamt    <= 5'd0;
        eff_sub  <= 1'b0;
        special  <= SP_NONE;
      end
      case (state)
        S_UNPACK: begin
          swap     <= (b_exp > a_exp);
          n_concat <= {a_zden, b_zden};
          shamt    <= sat_shamt(a_exp, b_exp);
          eff_sub  <= a_sign ^ b_sign ^ sub_req;
        end
        S_ADD:     norm_cnt <= 5'(NORM_MAX - 1);
        S_NORM: begin
          if (norm_done || norm_tc) begin
            norm_cnt <= 5'd0;
            if (!norm_done) norm_err <= 1'b1;
          end else begin
            norm_cnt <= norm_cnt - 5'd1;
          end
        end
        S_SPECIAL: special <= is_qnan ? SP_QNAN : SP_INF;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
module tb_fp_add_seq;

`ifdef FPU_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sign_a = 1'b0, sign_b = 1'b0;
  logic [7:0] exp_a = 8'd0, exp_b = 8'd0;
  logic       man_a_nz = 1'b0, man_b_nz = 1'b0;
  logic       op_sub = 1'b0;
  logic       swap;
  logic [1:0] n_concat;
  logic [4:0] shamt;
  logic       eff_sub;
  logic       ld_en, align_en, add_en, norm_en, round_en;
  logic       norm_done = 1'b0;
  logic [1:0] special;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       norm_err;

  int tests = 0;
  int fails = 0;

  // norm_done schedule and per-transaction enable counts
  int target_n = 0;
  int norm_seen = 0;
  int cnt_ld = 0, cnt_align = 0, cnt_add = 0, cnt_norm = 0, cnt_round = 0;
  int last_lat = 0;
  bit model_err = 1'b0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .man_a_nz  (man_a_nz),
    .man_b_nz  (man_b_nz),
`ifdef FPU_SUB_EN
    .op_sub    (op_sub),
`endif
    .swap      (swap),
    .n_concat  (n_concat),
    .shamt     (shamt),
    .eff_sub   (eff_sub),
    .ld_en     (ld_en),
    .align_en  (align_en),
    .add_en    (add_en),
    .norm_en   (norm_en),
    .round_en  (round_en),
    .norm_done (norm_done),
    .special   (special),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm_err  (norm_err)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle monitor: enable exclusivity, ready/valid exclusivity,
  // enable counting, and the norm_done responder.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      chk("one_hot_enables", ($countones({ld_en, align_en, add_en, norm_en, round_en}) <= 1), 1);
      if (out_valid) chk("ready_while_valid", in_ready, 0);
    end
    if (ld_en) begin
      cnt_ld = 1; cnt_align = 0; cnt_add = 0; cnt_norm = 0; cnt_round = 0;
      norm_seen = 0;
    end
    if (align_en) cnt_align++;
    if (add_en)   cnt_add++;
    if (round_en) cnt_round++;
    norm_done = norm_en && (target_n != 0) && (norm_seen + 1 == target_n);
    if (norm_en) begin
      cnt_norm++;
      norm_seen++;
    end
  end

  // Behavioural model: expected outputs straight from the operand rules.
  task automatic run_op(input bit sa, input bit sb, input int ea, input int eb,
                        input bit ma, input bit mb, input bit op, input int n,
                        input int hold, input bit poke);
    int  diff, m_shamt, m_lat, m_norm, cyc;
    bit  m_swap, m_eff, a_nan, b_nan, a_inf, b_inf, spc;
    int  m_sp;
    m_swap  = (eb > ea);
    diff    = (ea > eb) ? ea - eb : eb - ea;
    m_shamt = (diff > 24) ? 24 : diff;
    m_eff   = sa ^ sb ^ (op & SUB_EN);
    a_nan   = (ea == 255) && ma;  a_inf = (ea == 255) && !ma;
    b_nan   = (eb == 255) && mb;  b_inf = (eb == 255) && !mb;
    spc     = (ea == 255) || (eb == 255);
    if (!spc)                                     m_sp = 0;
    else if (a_nan || b_nan || (a_inf && b_inf && m_eff)) m_sp = 1;
    else                                          m_sp = 2;
    m_norm  = spc ? 0 : ((n == 0 || n > 26) ? 26 : n);
    m_lat   = spc ? 3 : 5 + m_norm;
    if (!spc && (n == 0 || n > 26)) model_err = 1'b1;

    target_n = n;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    sign_a = sa; sign_b = sb; exp_a = 8'(ea); exp_b = 8'(eb);
    man_a_nz = ma; man_b_nz = mb; op_sub = op;
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) in_valid = 1'b0;
      if (poke && cyc == 3) begin
        in_valid = 1'b1;
        exp_a = ~exp_a;
        exp_b = 8'd3;
      end
      if (!out_valid) chk("busy_not_ready", in_ready, 0);
    end while (!out_valid && cyc < 60);
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    last_lat = cyc;
    chk("latency", cyc, m_lat);
    chk("ld_count", cnt_ld, 1);
    chk("align_count", cnt_align, spc ? 0 : 1);
    chk("add_count", cnt_add, spc ? 0 : 1);
    chk("norm_count", cnt_norm, m_norm);
    chk("round_count", cnt_round, spc ? 0 : 1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("out_valid_hold", out_valid, 1);
      chk("swap", swap, m_swap);
      chk("n_concat", n_concat, {ea == 0, eb == 0});
      chk("shamt", shamt, m_shamt);
      chk("eff_sub", eff_sub, m_eff);
      chk("special", special, m_sp);
      chk("norm_err", norm_err, model_err);
      chk("no_enable_in_done", {ld_en, align_en, add_en, norm_en, round_en}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 0);
    chk("ready_after_done", in_ready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_swap"}, swap, 0);
    chk({tag, "_n_concat"}, n_concat, 0);
    chk({tag, "_shamt"}, shamt, 0);
    chk({tag, "_eff_sub"}, eff_sub, 0);
    chk({tag, "_special"}, special, 0);
    chk({tag, "_enables"}, {ld_en, align_en, add_en, norm_en, round_en}, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_norm_err"}, norm_err, 0);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // 130 vs 127, norm_done on first NORM cycle
    run_op(0, 0, 130, 127, 1, 1, 0, 1, 0, 0);
    chk("v1_lat_literal", last_lat, 6);
    chk("v1_swap_literal", swap, 0);
    chk("v1_shamt_literal", shamt, 3);
    chk("v1_nc_literal", n_concat, 0);

    // zero/denorm A against large B: shift saturates
    run_op(0, 0, 0, 200, 0, 1, 0, 3, 2, 0);
    chk("v2_swap_literal", swap, 1);
    chk("v2_nc_literal", n_concat, 2'b10);
    chk("v2_shamt_literal", shamt, 24);
    chk("v2_lat_literal", last_lat, 8);

    // NaN operand
    run_op(0, 0, 255, 100, 1, 0, 0, 1, 0, 0);
    chk("v3_special_literal", special, 2'b01);
    chk("v3_lat_literal", last_lat, 3);

    // Inf - Inf -> qNaN; Inf + Inf -> Inf
    if (SUB_EN) run_op(0, 0, 255, 255, 0, 0, 1, 1, 0, 0);
    else        run_op(0, 1, 255, 255, 0, 0, 0, 1, 0, 0);
    chk("v4_special_literal", special, 2'b01);
    run_op(0, 0, 255, 255, 0, 0, 0, 1, 0, 0);
    chk("v5_special_literal", special, 2'b10);

    // single Inf on B with finite A
    run_op(1, 0, 5, 255, 1, 0, 0, 1, 0, 0);
    chk("v6_special_literal", special, 2'b10);

    // equal exponents, opposite signs; in_valid offered during ADD
    run_op(0, 1, 100, 100, 1, 1, 0, 2, 0, 1);
    chk("v7_eff_sub_literal", eff_sub, 1);
    chk("v7_shamt_literal", shamt, 0);

    // shift exactly 24 and 25 (saturated), both zero
    run_op(0, 0, 10, 34, 1, 0, 0, 5, 0, 0);
    run_op(0, 0, 35, 10, 1, 1, 0, 4, 0, 0);
    chk("v9_shamt_literal", shamt, 24);
    run_op(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("v10_nc_literal", n_concat, 2'b11);

    // norm_done on the last allowed NORM cycle: no error
    run_op(0, 0, 140, 120, 1, 1, 0, 26, 0, 0);
    chk("v11_lat_literal", last_lat, 31);
    chk("v11_err_literal", norm_err, 0);

    // norm_done never arrives: timeout, held 10 cycles
    run_op(0, 0, 140, 120, 1, 1, 0, 0, 10, 0);
    chk("v12_lat_literal", last_lat, 31);
    chk("v12_err_literal", norm_err, 1);

    // error is sticky across a clean operation
    run_op(0, 0, 127, 127, 0, 0, 0, 1, 0, 0);
    chk("v13_err_sticky", norm_err, 1);

    // reset in the middle of NORM
    target_n = 0;
    @(negedge clk);
    sign_a = 0; sign_b = 0; exp_a = 8'd0; exp_b = 8'd200;
    man_a_nz = 0; man_b_nz = 1; op_sub = 0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!norm_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reached_norm", norm_en, 1);
    chk("pre_reset_swap", swap, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", in_ready, 1);
    chk("valid_after_midreset", out_valid, 0);
    run_op(0, 0, 131, 129, 1, 0, 0, 2, 0, 0);
    chk("post_reset_err", norm_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
